pwm_multi_gen: RTL and testbench

- Multi-channel PWM generator for the motor/fan drive path, and the parametrised successor of the single-channel PWM block.
- One shared period counter drives CH_NUM compare channels. The counter supports edge-aligned or center-aligned counting.
- Period, duties and mode are double-buffered: software writes staging values, which commit only at a period boundary, so no glitched or truncated pulses occur.
- Sits behind the AXI-lite register slave; the outputs go to the H-bridge/fan drivers.

---
 rtl/pwm_pkg.sv | 12 +
 rtl/pwm_deadtime.sv | 35 +++
 rtl/pwm_multi_gen.sv | 108 ++++++++++
 tb/tb_pwm_multi_gen.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// pwm_pkg: shared mode encoding, default widths and per-channel duty slice helper
package pwm_pkg;
    localparam logic PWM_MODE_EDGE   = 1'b0;
    localparam logic PWM_MODE_CENTER = 1'b1;
    localparam int PWM_CNT_W    = 32;
    localparam int PWM_DT_W     = 8;
    localparam int PWM_MAX_BITS = 1024;

    function automatic logic [63:0] duty_slice(input logic [PWM_MAX_BITS-1:0] duties, input int ch, input int w);
        return 64'(duties >> (ch * w));
    endfunction
endpackage

// File: rtl/pwm_deadtime.sv
// pwm_deadtime: complementary output pair; both sides low for dead_time cycles after each raw edge
module pwm_deadtime #(
    parameter int DT_W = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic            raw,
    input  logic [DT_W-1:0] dead_time,
    output logic            p,
    output logic            n
);
    logic raw_q, r, flip, blocked;
    logic [DT_W-1:0] dly;

    always_comb begin
        r = en & raw;
        flip = r ^ raw_q;
        blocked = flip ? dead_time != '0 : dly > DT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            raw_q <= 1'b0;
            dly <= '0;
            p <= 1'b0;
            n <= 1'b0;
        end else begin
            raw_q <= r;
            dly <= flip ? dead_time : (dly != '0 ? dly - 1'b1 : '0);
            p <= r & !blocked;
            n <= en & !r & !blocked;
        end
    end
endmodule

// File: rtl/pwm_multi_gen.sv
// pwm_multi_gen: shared-counter multi-channel PWM with double-buffered config; PWM_DEADTIME_EN adds complementary outputs
module pwm_multi_gen
    import pwm_pkg::*;
#(
    parameter int CH_NUM = 4,
    parameter int CNT_W  = PWM_CNT_W
`ifdef PWM_DEADTIME_EN
    , parameter int DT_W = PWM_DT_W
`endif
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    mode_set,
    input  logic [CNT_W-1:0]        period_set,
    input  logic [CH_NUM*CNT_W-1:0] duty_set,
    input  logic                    load,
`ifdef PWM_DEADTIME_EN
    input  logic [DT_W-1:0]         dead_time,
    output logic [CH_NUM-1:0]       pwm_n_o,
`endif
    output logic [CH_NUM-1:0]       pwm_o,
    output logic                    period_end,
    output logic                    pending
);
    logic [CNT_W-1:0] cnt, act_period, stg_period;
    logic [CH_NUM*CNT_W-1:0] act_duty, stg_duty;
    logic act_mode, stg_mode, dir, start;
    logic [CH_NUM-1:0] raw;
    logic boundary, commit;

    // start marks the first enabled cycle so center mode can commit right away
    always_comb begin
        boundary = act_period == '0 ||
                   (act_mode == PWM_MODE_CENTER ? cnt == '0 && (dir || start) : cnt == act_period);
        commit = (!en || boundary) && (pending || load);
    end

    for (genvar i = 0; i < CH_NUM; i++) begin : g_cmp
        assign raw[i] = CNT_W'(duty_slice(PWM_MAX_BITS'(act_duty), i, CNT_W)) > cnt;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
            dir <= 1'b0;
            start <= 1'b1;
            act_period <= '0;
            act_duty <= '0;
            act_mode <= PWM_MODE_EDGE;
            stg_period <= '0;
            stg_duty <= '0;
            stg_mode <= PWM_MODE_EDGE;
            pending <= 1'b0;
            period_end <= 1'b0;
        end else begin
            period_end <= en && boundary;
            start <= !en;
            pending <= !commit && (pending || load);
            if (load) begin
                stg_mode <= mode_set;
                stg_period <= period_set;
                stg_duty <= duty_set;
            end
            if (commit) begin
                act_mode <= load ? mode_set : stg_mode;
                act_period <= load ? period_set : stg_period;
                act_duty <= load ? duty_set : stg_duty;
            end
            // equality is tested before any increment, so P = all-ones never wraps
            if (!en || commit) begin
                cnt <= '0;
                dir <= 1'b0;
            end else if (act_period == '0) begin
                cnt <= '0;
            end else if (act_mode == PWM_MODE_EDGE) begin
                cnt <= cnt == act_period ? '0 : cnt + 1'b1;
            end else if (!dir) begin
                cnt <= cnt == act_period ? cnt - 1'b1 : cnt + 1'b1;
                dir <= cnt == act_period;
            end else begin
                cnt <= cnt == '0 ? CNT_W'(1) : cnt - 1'b1;
                dir <= cnt != '0;
            end
        end
    end

`ifdef PWM_DEADTIME_EN
    for (genvar i = 0; i < CH_NUM; i++) begin : g_dt
        pwm_deadtime #(.DT_W(DT_W)) u_dt (
            .clk(clk),
            .rst_n(rst_n),
            .en(en),
            .raw(raw[i]),
            .dead_time(dead_time),
            .p(pwm_o[i]),
            .n(pwm_n_o[i])
        );
    end
`else
    always_ff @(posedge clk) begin
        if (!rst_n)
            pwm_o <= '0;
        else
            pwm_o <= en ? raw : '0;
    end
`endif
endmodule

// File: tb/tb_pwm_multi_gen.sv
// tb_pwm_multi_gen: directed checks of counting, staging, commit, reset and optional dead-time
module tb_pwm_multi_gen;
    localparam int CH = 4;
    localparam int W  = 8;

    logic clk = 1'b0;
    logic rst_n, en, mode_set, load;
    logic [W-1:0] period_set;
    logic [CH*W-1:0] duty_set;
    logic [CH-1:0] pwm_o;
    logic period_end, pending;
`ifdef PWM_DEADTIME_EN
    logic [7:0] dead_time;
    logic [CH-1:0] pwm_n_o;
`endif
    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    pwm_multi_gen #(.CH_NUM(CH), .CNT_W(W)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .en(en),
        .mode_set(mode_set),
        .period_set(period_set),
        .duty_set(duty_set),
        .load(load),
`ifdef PWM_DEADTIME_EN
        .dead_time(dead_time),
        .pwm_n_o(pwm_n_o),
`endif
        .pwm_o(pwm_o),
        .period_end(period_end),
        .pending(pending)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // config is committed directly while en is low; the next edge is the first counting edge
    task automatic setup(input logic m, input logic [W-1:0] p, input logic [CH*W-1:0] d);
        rst_n = 1'b0;
        en = 1'b0;
        load = 1'b0;
        mode_set = 1'b0;
        period_set = '0;
        duty_set = '0;
        tick();
        tick();
        rst_n = 1'b1;
        mode_set = m;
        period_set = p;
        duty_set = d;
        load = 1'b1;
        tick();
        load = 1'b0;
        en = 1'b1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        en = 1'b1;
        load = 1'b1;
        mode_set = 1'b0;
        period_set = 8'd9;
        duty_set = '1;
        tick();
        tick();
        checks++; if (pwm_o !== 4'b0000) $display("FAIL reset_pwm got %b exp 0000", pwm_o); else passed++;
        checks++; if (period_end !== 1'b0) $display("FAIL reset_period_end got %b exp 0", period_end); else passed++;
        checks++; if (pending !== 1'b0) $display("FAIL reset_pending got %b exp 0", pending); else passed++;
        load = 1'b0;
    endtask

    task automatic test_edge;
        logic [3:0] exp;
        setup(1'b0, 8'd9, {8'd12, 8'd10, 8'd3, 8'd0});
        checks++; if (pending !== 1'b0) $display("FAIL edge_load_idle_pending got %b exp 0", pending); else passed++;
        for (int k = 1; k <= 34; k++) begin
            tick();
            exp = {2'b11, ((k - 1) % 10 < 3), 1'b0};
            checks++; if (pwm_o !== exp) $display("FAIL edge_pwm k=%0d got %b exp %b", k, pwm_o, exp); else passed++;
            checks++; if (period_end !== (k % 10 == 0)) $display("FAIL edge_period_end k=%0d got %b exp %b", k, period_end, (k % 10 == 0)); else passed++;
        end
        en = 1'b0;
        tick();
        checks++; if (pwm_o !== 4'b0000) $display("FAIL edge_disabled_pwm got %b exp 0000", pwm_o); else passed++;
        checks++; if (period_end !== 1'b0) $display("FAIL edge_disabled_period_end got %b exp 0", period_end); else passed++;
        en = 1'b1;
        tick();
        checks++; if (pwm_o !== 4'b1110) $display("FAIL edge_restart_pwm got %b exp 1110", pwm_o); else passed++;
    endtask

    task automatic test_staging;
        logic e1;
        setup(1'b0, 8'd9, {8'd0, 8'd0, 8'd3, 8'd0});
        for (int k = 1; k <= 20; k++) begin
            tick();
            e1 = k <= 10 ? (k - 1) < 3 : (k - 11) < 7;
            checks++; if (pwm_o[1] !== e1) $display("FAIL staging_ch1 k=%0d got %b exp %b", k, pwm_o[1], e1); else passed++;
            checks++; if (pending !== (k >= 5 && k <= 9)) $display("FAIL staging_pending k=%0d got %b exp %b", k, pending, (k >= 5 && k <= 9)); else passed++;
            checks++; if (period_end !== (k % 10 == 0)) $display("FAIL staging_period_end k=%0d got %b exp %b", k, period_end, (k % 10 == 0)); else passed++;
            if (k == 4) begin
                duty_set = {8'd0, 8'd0, 8'd7, 8'd0};
                load = 1'b1;
            end
            if (k == 5) load = 1'b0;
        end
    endtask

    task automatic test_load_boundary;
        logic e1;
        setup(1'b0, 8'd9, {8'd0, 8'd0, 8'd3, 8'd0});
        for (int k = 1; k <= 20; k++) begin
            tick();
            e1 = k <= 10 ? (k - 1) < 3 : (k - 11) < 7;
            checks++; if (pwm_o[1] !== e1) $display("FAIL bypass_ch1 k=%0d got %b exp %b", k, pwm_o[1], e1); else passed++;
            checks++; if (pending !== 1'b0) $display("FAIL bypass_pending k=%0d got %b exp 0", k, pending); else passed++;
            if (k == 9) begin
                duty_set = {8'd0, 8'd0, 8'd7, 8'd0};
                load = 1'b1;
            end
            if (k == 10) load = 1'b0;
        end
    endtask

    task automatic test_center;
        logic c0, pe;
        int m;
        setup(1'b1, 8'd4, {8'd0, 8'd5, 8'd0, 8'd2});
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (k <= 25) begin
                m = (k - 1) % 8;
                c0 = m < 2 || m == 7;
                pe = m == 0;
            end else begin
                m = (k - 26) % 5;
                c0 = m < 2;
                pe = m == 4;
            end
            checks++; if (pwm_o !== {2'b01, 1'b0, c0}) $display("FAIL center_pwm k=%0d got %b exp %b", k, pwm_o, {2'b01, 1'b0, c0}); else passed++;
            checks++; if (period_end !== pe) $display("FAIL center_period_end k=%0d got %b exp %b", k, period_end, pe); else passed++;
            checks++; if (pending !== (k >= 21 && k <= 24)) $display("FAIL center_pending k=%0d got %b exp %b", k, pending, (k >= 21 && k <= 24)); else passed++;
            if (k == 20) begin
                mode_set = 1'b0;
                load = 1'b1;
            end
            if (k == 21) load = 1'b0;
        end
    endtask

    task automatic test_reset_mid;
        setup(1'b0, 8'd9, {8'd0, 8'd0, 8'd3, 8'd12});
        for (int k = 1; k <= 5; k++) begin
            tick();
            if (k == 3) begin
                duty_set = {8'd0, 8'd0, 8'd7, 8'd12};
                load = 1'b1;
            end
            if (k == 4) load = 1'b0;
        end
        checks++; if (pending !== 1'b1) $display("FAIL midreset_pending_before got %b exp 1", pending); else passed++;
        checks++; if (pwm_o !== 4'b0001) $display("FAIL midreset_pwm_before got %b exp 0001", pwm_o); else passed++;
        rst_n = 1'b0;
        tick();
        checks++; if (pwm_o !== 4'b0000) $display("FAIL midreset_pwm got %b exp 0000", pwm_o); else passed++;
        checks++; if (pending !== 1'b0) $display("FAIL midreset_pending got %b exp 0", pending); else passed++;
        checks++; if (period_end !== 1'b0) $display("FAIL midreset_period_end got %b exp 0", period_end); else passed++;
        rst_n = 1'b1;
        for (int j = 1; j <= 12; j++) begin
            tick();
            checks++; if (pwm_o !== 4'b0000) $display("FAIL postreset_pwm j=%0d got %b exp 0000", j, pwm_o); else passed++;
            checks++; if (pending !== 1'b0) $display("FAIL postreset_pending j=%0d got %b exp 0", j, pending); else passed++;
            checks++; if (period_end !== 1'b1) $display("FAIL postreset_period_end j=%0d got %b exp 1", j, period_end); else passed++;
        end
    endtask

`ifdef PWM_DEADTIME_EN
    task automatic test_deadtime;
        logic ep, en_exp;
        int m;
        dead_time = 8'd3;
        setup(1'b0, 8'd9, {8'd0, 8'd0, 8'd0, 8'd5});
        for (int k = 1; k <= 30; k++) begin
            tick();
            m = (k - 1) % 10;
            ep = m == 3 || m == 4;
            en_exp = m == 8 || m == 9;
            checks++; if (pwm_o[0] !== ep) $display("FAIL dt_p k=%0d got %b exp %b", k, pwm_o[0], ep); else passed++;
            checks++; if (pwm_n_o[0] !== en_exp) $display("FAIL dt_n k=%0d got %b exp %b", k, pwm_n_o[0], en_exp); else passed++;
            checks++; if ((pwm_o[0] & pwm_n_o[0]) !== 1'b0) $display("FAIL dt_overlap k=%0d got %b exp 0", k, pwm_o[0] & pwm_n_o[0]); else passed++;
        end
    endtask
`endif

    initial begin
`ifdef PWM_DEADTIME_EN
        dead_time = 8'd0;
`endif
        test_reset();
        test_edge();
        test_staging();
        test_load_boundary();
        test_center();
        test_reset_mid();
`ifdef PWM_DEADTIME_EN
        test_deadtime();
`endif
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
